// File: rtl/fifo_wptr_gray.sv
// fifo_wptr_gray: write-side binary/Gray pointer pair, read-pointer synchronizer, full flag and fill level.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) bin[i] = ^(gray >> i);
  end
endmodule

module fifo_wptr_gray #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  winc_i,
  input  logic [ADDR_WIDTH:0]   rptr_gray_i,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [ADDR_WIDTH:0]   wptr_gray_o,
  output logic                  wfull_o,
  output logic [ADDR_WIDTH:0]   wlevel_o
);
  logic [ADDR_WIDTH:0] wbin, wgray, wbin_next, wgray_next, rq_sync, rq_bin;
  logic [ADDR_WIDTH:0] sync [SYNC_STAGES];
  logic                wfull;
  assign wen_o      = winc_i & ~wfull;
  assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wen_o};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign rq_sync    = sync[SYNC_STAGES-1];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wbin  <= '0;
      wgray <= '0;
      wfull <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else begin
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      sync[0] <= rptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
      wfull   <= wgray_next == {~rq_sync[ADDR_WIDTH:ADDR_WIDTH-1], rq_sync[ADDR_WIDTH-2:0]};
    end
  gray2bin #(.W(ADDR_WIDTH+1)) u_g2b (.gray(rq_sync), .bin(rq_bin));
  assign waddr_o     = wbin[ADDR_WIDTH-1:0];
  assign wptr_gray_o = wgray;
  assign wfull_o     = wfull;
  assign wlevel_o    = wbin - rq_bin;
endmodule
